// File: rtl/toggle_event_counter.sv
// Counts level changes on an upstream toggle line and emits the count over a
// valid/ready port when it reaches THRESH or on a flush request.
module toggle_event_counter #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             toggle_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic             edge_seen
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [CNT_W:0] THRESH_W = (CNT_W+1)'(THRESH);

  state_t           state_q, state_d;
  logic             toggle_prev_q, toggle_prev_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] out_data_q, out_data_d;
  logic             overrun_q, overrun_d;
  logic             edge_seen_q, edge_seen_d;

  logic             event_w;
  logic [CNT_W:0]   sum;
  logic             emit;

  always_comb begin
    event_w       = (toggle_in ^ toggle_prev_q) & enable;
    sum           = {1'b0, acc_q} + {{CNT_W{1'b0}}, event_w};
    emit          = (sum == THRESH_W) | (flush & (sum != '0));

    toggle_prev_d = toggle_in;
    edge_seen_d   = event_w;
    acc_d         = emit ? '0 : sum[CNT_W-1:0];
    state_d       = state_q;
    out_data_d    = out_data_q;
    overrun_d     = overrun_q;

    case (state_q)
      EMPTY: begin
        if (emit) begin
          out_data_d = sum[CNT_W-1:0];
          state_d    = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (emit) begin
            out_data_d = sum[CNT_W-1:0];
          end else begin
            state_d = EMPTY;
          end
        end else if (emit) begin
          // Output still occupied: the new count is lost but acc is cleared.
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= EMPTY;
      toggle_prev_q <= 1'b0;
      acc_q         <= '0;
      out_data_q    <= '0;
      overrun_q     <= 1'b0;
      edge_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      toggle_prev_q <= toggle_prev_d;
      acc_q         <= acc_d;
      out_data_q    <= out_data_d;
      overrun_q     <= overrun_d;
      edge_seen_q   <= edge_seen_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;
  assign edge_seen = edge_seen_q;

endmodule

// File: tb/tb_toggle_event_counter.sv
// Scoreboard bench for toggle_event_counter: directed scenarios followed by
// randomized traffic, checked against an event-count model.
module tb_toggle_event_counter;

  localparam int CNT_W = 8;
  localparam int TH    = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable = 1'b0;
  logic             toggle_in = 1'b0;
  logic             flush = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_data;
  logic             out_valid;
  logic             overrun;
  logic             edge_seen;

  toggle_event_counter #(.CNT_W(CNT_W), .THRESH(TH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .toggle_in (toggle_in),
    .flush     (flush),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .overrun   (overrun),
    .edge_seen (edge_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: expected accepted emits, plus what the outputs should show now (cur_*)
  // and after the coming clock edge (nxt_*).
  int   exp_q[$];
  logic m_prev = 1'b0;
  int   m_count = 0;
  logic cur_valid = 0, nxt_valid = 0;
  int   cur_data = 0, nxt_data = 0;
  logic cur_ovr = 0, nxt_ovr = 0;
  logic cur_edge = 0, nxt_edge = 0;
  logic tog = 1'b0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic en, input logic tin, input logic fl, input logic rdy);
    int total;
    logic ev;
    @(posedge clk);
    #1;
    cur_valid = nxt_valid; cur_data = nxt_data; cur_ovr = nxt_ovr; cur_edge = nxt_edge;
    enable = en; toggle_in = tin; flush = fl; out_ready = rdy;
    ev     = (tin != m_prev) && en;
    m_prev = tin;
    total  = m_count + int'(ev);
    nxt_edge = ev;
    if (total == TH || (fl && total != 0)) begin
      m_count = 0;
      if (!cur_valid || rdy) begin
        exp_q.push_back(total);
        nxt_valid = 1'b1;
        nxt_data  = total;
      end else begin
        nxt_ovr = 1'b1;
      end
    end else begin
      m_count = total;
      if (cur_valid && rdy) nxt_valid = 1'b0;
    end
  endtask

  task automatic flips(input int n, input logic en, input logic rdy);
    for (int i = 0; i < n; i++) begin
      tog = ~tog;
      cycle(en, tog, 1'b0, rdy);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, tog, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rstn = 1'b0; toggle_in = 1'b0; tog = 1'b0; enable = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_edge_seen", int'(edge_seen), 0);
    exp_q.delete();
    m_prev = 0; m_count = 0;
    cur_valid = 0; nxt_valid = 0; cur_data = 0; nxt_data = 0;
    cur_ovr = 0; nxt_ovr = 0; cur_edge = 0; nxt_edge = 0;
    @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  // Monitor: per-cycle output checks and handshake-driven scoreboard pops.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && mon_en) begin
        chk("out_valid", int'(out_valid), int'(cur_valid));
        chk("overrun", int'(overrun), int'(cur_ovr));
        chk("edge_seen", int'(edge_seen), int'(cur_edge));
        if (cur_valid) chk("out_data_held", int'(out_data), cur_data);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_emit", int'(out_data), -1);
          end else begin
            $display("xfer data=%0d", out_data);
            chk("xfer_data", int'(out_data), exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_overrun", int'(overrun), 0);
    do_reset();
    mon_en = 1'b1;

    // Threshold emit with ready high.
    flips(4, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Partial flush, then an empty flush that must not emit.
    flips(3, 1'b1, 1'b1);
    cycle(1'b1, tog, 1'b1, 1'b1);
    idle(2, 1'b1);
    cycle(1'b1, tog, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Backpressure and overrun.
    flips(4, 1'b1, 1'b0);
    idle(1, 1'b0);
    flips(4, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    // Back-to-back emit while the previous one is accepted.
    do_reset();
    flips(4, 1'b1, 1'b0);
    flips(3, 1'b1, 1'b0);
    tog = ~tog;
    cycle(1'b1, tog, 1'b0, 1'b1);
    idle(3, 1'b1);
    // Disabled toggles are not counted; flush shows acc=1.
    flips(3, 1'b0, 1'b1);
    flips(1, 1'b1, 1'b1);
    idle(1, 1'b1);
    cycle(1'b1, tog, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Reset while FULL with a partial count, then a clean group of 4.
    flips(4, 1'b1, 1'b0);
    flips(2, 1'b1, 1'b0);
    do_reset();
    flips(4, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom % 4) != 0, $urandom % 2, ($urandom % 8) == 0, ($urandom % 3) != 0);
    end
    idle(4, 1'b1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toggle_event_counter.md
Name: toggle_event_counter

Overview:
Downstream consumer of the single-bit toggle-state FSM output. Every level change of the toggle line counts as one event. Events accumulate in a counter. When the count reaches THRESH, or on an explicit flush, the count is emitted over a valid/ready output port. Non-triplicated source; the TMR flow triplicates it later like its upstream neighbour.

Parameters:
CNT_W, 8, width of accumulator and out_data
THRESH, 16, event count that forces an emit; legal range 1..2^CNT_W-1

Ports:
clk  input  1  single clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
enable  input  1  gates event counting; edge tracking continues when low
toggle_in  input  1  toggle-state output of upstream FSM
flush  input  1  emit partial count (single-cycle request)
out_ready  input  1  consumer accepts out_data
out_data  output  CNT_W  emitted event count
out_valid  output  1  out_data valid
overrun  output  1  sticky: an emit was dropped because the output was occupied
edge_seen  output  1  registered one-cycle pulse per counted event

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rstn).
- Reset values (async, rstn=0):
  - toggle_prev=0, acc=0, out_data=0, out_valid=0, overrun=0, edge_seen=0.
- Edge detection:
  - toggle_prev <= toggle_in every cycle, regardless of enable.
  - event = (toggle_in ^ toggle_prev) & enable, combinational.
  - Upstream also resets to 0, so no spurious event occurs after reset.
- Accumulator:
  - sum = acc + event, computed CNT_W+1 wide. sum never exceeds THRESH.
  - emit = (sum == THRESH) | (flush & (sum != 0)).
  - If emit: acc <= 0. Otherwise: acc <= sum[CNT_W-1:0].
  - flush with sum==0 is ignored. No empty emits.
- Output FSM (two states, encoded by out_valid):
  - EMPTY (out_valid=0):
    - emit -> load out_data=sum, go to FULL.
  - FULL (out_valid=1):
    - out_ready=1 and emit -> load new sum; stay FULL. Back-to-back, no bubble.
    - out_ready=1, no emit -> go to EMPTY. out_data holds its last value.
    - out_ready=0 and emit -> new value is dropped, overrun <= 1, acc still cleared, out_data unchanged.
    - out_ready=0, no emit -> hold.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- Latency: the edge on toggle_in in cycle n that completes THRESH raises out_valid at posedge n+1. edge_seen pulses in cycle n+1 for every counted event.
- overrun is sticky and is cleared only by rstn.
- Flush and threshold in the same cycle: a single emit with value THRESH.
- Reset mid-operation: everything returns to its reset value immediately. A pending out_data is discarded and partial counts are lost.
- enable low: no events counted, but toggle_prev keeps tracking. A toggle that occurs while disabled is not counted after re-enable.

Test Plan:
- THRESH=4, out_ready=1, toggle_in flips on 4 consecutive cycles -> out_valid=1 with out_data=4 one cycle after the 4th flip; edge_seen pulses 4 times; acc=0.
- 3 flips, then flush=1 for one cycle -> out_data=3 emitted next cycle. A second flush with no new flips -> no emit, out_valid drops after the handshake.
- out_ready=0, 4 flips -> out_valid=1, data=4 held. 4 more flips -> overrun=1, out_data still 4. Raise out_ready -> accepted, out_valid=0, overrun stays 1.
- out_valid=1, out_ready=1 on the cycle the next group of 4 completes -> out_data becomes 4 again, out_valid stays 1 with no gap, overrun=0.
- enable=0 during 3 flips, then enable=1 and 1 flip -> acc=1, no emit. Flips during enable=0 are not counted.
- rstn pulsed low while FULL with acc=2 -> out_valid, out_data, acc and overrun read 0 asynchronously. After release, 4 flips -> out_data=4.
